// File: rtl/pc_branch_sequencer.sv
// Program counter and fetch/execute sequencer driving the next-PC branch select.
// Optional BRANCH_STATS_EN macro adds a saturating taken-branch counter port.
module pc_branch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imm_offset,
    input  logic        halt,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic        branch_next,
    output logic        fetch_valid,
    output logic        fetch_error
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] taken_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {imm_offset[29:0], 2'b00};
    assign branch_next   = (state == S_EXEC) & branch & zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    // Ack is checked first so a late ack on the final wait cycle still wins.
                    if (imem_ack) begin
                        state       <= S_EXEC;
                        imem_req    <= 1'b0;
                        fetch_valid <= 1'b1;
                        wait_cnt    <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= S_HALTED;
                        imem_req    <= 1'b0;
                        fetch_error <= 1'b1;
                        wait_cnt    <= wait_cnt + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    fetch_valid <= 1'b0;
                    if (halt) begin
                        state <= S_HALTED;
                    end else begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        if (jump)
                            pc <= jump_target;
                        else if (branch_next)
                            pc <= branch_target;
                        else
                            pc <= pc_plus4;
                    end
                end
                default: begin
                    state       <= S_HALTED;
                    imem_req    <= 1'b0;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            taken_count <= '0;
        else if (branch_next && !halt && !jump && (taken_count != '1))
            taken_count <= taken_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed bench for pc_branch_sequencer: sequential fetch, branches, jump/halt
// priority, fetch timeout, PC wrap-around, async reset and optional taken counter.
module tb_pc_branch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] imm_offset = '0;
    logic        halt = 1'b0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        branch_next;
    logic        fetch_valid;
    logic        fetch_error;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pc_branch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branch        (branch),
        .zero          (zero),
        .jump          (jump),
        .jump_target   (jump_target),
        .imm_offset    (imm_offset),
        .halt          (halt),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .branch_next   (branch_next),
        .fetch_valid   (fetch_valid),
        .fetch_error   (fetch_error)
`ifdef BRANCH_STATS_EN
        ,
        .taken_count   (taken_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic br, input logic z, input logic j,
                           input logic [31:0] jt, input logic [31:0] imm, input logic h);
        branch = br; zero = z; jump = j; jump_target = jt; imm_offset = imm; halt = h;
    endtask

    // From FETCH: ack one cycle and land in EXEC.
    task automatic to_exec();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
    endtask

    // Reset pulse, then one edge so the DUT is in FETCH.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'b0, fetch_valid}, 32'd0);
        check_eq("rst_bn", {31'b0, branch_next}, 32'd0);
        check_eq("rst_err", {31'b0, fetch_error}, 32'd0);
        reset = 1'b0;
        check_eq("idle_req", {31'b0, imem_req}, 32'd0);
        tick();
        check_eq("first_req", {31'b0, imem_req}, 32'd1);
        check_eq("first_pc", pc, 32'h0);

        // Sequential fetch 0x0, 0x4, 0x8, 0xC
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_fetch_pc", pc, 32'(4 * i));
            check_eq("seq_fetch_req", {31'b0, imem_req}, 32'd1);
            check_eq("seq_fetch_nv", {31'b0, fetch_valid}, 32'd0);
            to_exec();
            check_eq("seq_exec_valid", {31'b0, fetch_valid}, 32'd1);
            check_eq("seq_exec_req", {31'b0, imem_req}, 32'd0);
            check_eq("seq_exec_pc", pc, 32'(4 * i));
            tick();
        end

        // Taken branch at 0x10
        check_eq("br_pc", pc, 32'h10);
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0, 32'd3, 1'b0);
        check_eq("fetch_bn_gated", {31'b0, branch_next}, 32'd0);
        to_exec();
        check_eq("br_taken_bn", {31'b0, branch_next}, 32'd1);
        check_eq("br_target", branch_target, 32'h20);
        tick();
        check_eq("br_taken_pc", pc, 32'h20);
        // Jump back to 0x10, then not-taken branch
        to_exec();
        set_ctl(1'b0, 1'b0, 1'b1, 32'h10, 32'd0, 1'b0);
        tick();
        check_eq("jmp_back_pc", pc, 32'h10);
        to_exec();
        set_ctl(1'b1, 1'b0, 1'b0, 32'h0, 32'd3, 1'b0);
        check_eq("br_nt_bn", {31'b0, branch_next}, 32'd0);
        tick();
        check_eq("br_nt_pc", pc, 32'h14);

        // Jump beats branch
        to_exec();
        set_ctl(1'b1, 1'b1, 1'b1, 32'h100, 32'd3, 1'b0);
        tick();
        check_eq("jmp_wins_pc", pc, 32'h100);
        // Halt beats jump
        to_exec();
        set_ctl(1'b1, 1'b1, 1'b1, 32'h200, 32'd3, 1'b1);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
        imem_ack = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0;
        check_eq("halt_pc", pc, 32'h100);
        check_eq("halt_req", {31'b0, imem_req}, 32'd0);
        check_eq("halt_valid", {31'b0, fetch_valid}, 32'd0);
        check_eq("halt_err", {31'b0, fetch_error}, 32'd0);

        // Timeout: 15 FETCH cycles with no ack
        do_reset();
        repeat (14) tick();
        check_eq("to_14_req", {31'b0, imem_req}, 32'd1);
        check_eq("to_14_err", {31'b0, fetch_error}, 32'd0);
        tick();
        check_eq("to_15_err", {31'b0, fetch_error}, 32'd1);
        check_eq("to_15_req", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check_eq("to_stuck_valid", {31'b0, fetch_valid}, 32'd0);
        check_eq("to_sticky_err", {31'b0, fetch_error}, 32'd1);

        // Ack on exactly the 15th FETCH cycle
        do_reset();
        check_eq("rst_clears_err", {31'b0, fetch_error}, 32'd0);
        repeat (14) tick();
        to_exec();
        check_eq("ack15_valid", {31'b0, fetch_valid}, 32'd1);
        check_eq("ack15_err", {31'b0, fetch_error}, 32'd0);

        // Wrap-around at 0xFFFFFFFC
        set_ctl(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);
        tick();
        set_ctl(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
        check_eq("wrap_plus4", pc_plus4, 32'h0);
        check_eq("wrap_target", branch_target, 32'hFFFF_FFFC);
        to_exec();
        check_eq("wrap_bn", {31'b0, branch_next}, 32'd1);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("wrap_next_pc", pc, 32'hFFFF_FFFC);
        check_eq("wrap_next_req", {31'b0, imem_req}, 32'd1);

        // Async reset mid-FETCH takes effect before any clock edge
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_pc", pc, 32'h0);
        check_eq("async_rst_req", {31'b0, imem_req}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Async reset mid-EXEC: the pending jump must not land
        to_exec();
        set_ctl(1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("exec_rst_valid", {31'b0, fetch_valid}, 32'd0);
        tick();
        check_eq("exec_rst_pc", pc, 32'h0);
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        tick();

`ifdef BRANCH_STATS_EN
        check_eq("cnt_rst", taken_count, 32'd0);
        to_exec(); set_ctl(1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 1'b0); tick();
        to_exec(); set_ctl(1'b1, 1'b0, 1'b0, 32'h0, 32'd1, 1'b0); tick();
        to_exec(); set_ctl(1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 1'b0); tick();
        to_exec(); set_ctl(1'b1, 1'b1, 1'b1, 32'h40, 32'd1, 1'b0); tick();
        to_exec(); set_ctl(1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 1'b0); tick();
        set_ctl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("cnt_taken", taken_count, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_sequencer.md
Name: pc_branch_sequencer

Overview:
- Sequential producer of the branch-select flag consumed by the next-PC branch/sequential mux.
- Holds the program counter and runs an instruction-fetch handshake with instruction memory.
- Computes PC+4 and the branch target, and drives branch_next during the execute cycle.
- Sits between the control unit / ALU zero flag and the next-PC mux; its pc output feeds instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, maximum cycles FETCH waits for imem_ack before flagging an error (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- branch  input  1  control unit: current instruction is a conditional branch.
- zero  input  1  ALU zero flag for the current instruction.
- jump  input  1  control unit: unconditional jump.
- jump_target  input  32  absolute jump address.
- imm_offset  input  32  sign-extended branch immediate, in words.
- halt  input  1  control unit: halt instruction decoded.
- imem_ack  input  1  instruction memory: instruction word valid this cycle.
- imem_req  output  1  fetch request to instruction memory.
- pc  output  32  current program counter.
- pc_plus4  output  32  pc + 4.
- branch_target  output  32  pc + 4 + (imm_offset << 2).
- branch_next  output  1  branch-taken select toward the next-PC mux.
- fetch_valid  output  1  instruction word is valid; execute cycle active.
- fetch_error  output  1  sticky; fetch timed out.

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=IDLE, imem_req=0, fetch_valid=0, branch_next=0, fetch_error=0, wait counter=0.
- States: IDLE, FETCH, EXEC, HALTED. Encoding is free.
- IDLE: all handshake outputs 0. Goes to FETCH on the next clock.
- FETCH:
  - imem_req=1.
  - Wait counter increments each cycle imem_ack=0.
  - imem_ack=1: go to EXEC and clear the counter.
  - Counter reaches MAX_WAIT with no ack: set fetch_error=1, go to HALTED.
  - imem_ack has priority over timeout in the same cycle.
- EXEC: exactly one cycle.
  - imem_req=0, fetch_valid=1.
  - branch_next = branch & zero (combinational, gated by state==EXEC; 0 in every other state).
  - At the clock edge the PC updates with priority halt > jump > branch_next > sequential:
    - halt: pc unchanged, go to HALTED.
    - jump: pc=jump_target.
    - branch_next: pc=branch_target.
    - otherwise: pc=pc_plus4.
  - Next state is FETCH unless halt.
- HALTED: imem_req=0, fetch_valid=0, pc frozen. Only reset exits.
- Arithmetic: all 32-bit, modulo 2^32, wrap-around silent.
  - pc 0xFFFFFFFC gives pc_plus4 = 0x00000000.
  - branch_target uses imm_offset shifted left 2; upper bits are discarded.
- pc_plus4 and branch_target are combinational from pc and imm_offset and valid in every state.
- Inputs branch, zero, jump, halt, jump_target and imm_offset are sampled only in EXEC and ignored elsewhere.
- Reset asserted mid-FETCH or mid-EXEC: no PC update takes effect. Outputs return to reset values immediately.
- First imem_req occurs in the 2nd cycle after reset deassertion, with pc=RESET_PC.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds output port taken_count (32 bits, reset 0).
  - taken_count increments at each EXEC clock edge where branch_next=1 and halt=0 and jump=0.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then imem_ack=1 on the first request, branch=0, jump=0 -> pc sequence 0x0, 0x4, 0x8, with one EXEC cycle (fetch_valid=1) per instruction.
2. pc=0x10, branch=1, zero=1, imm_offset=3 in EXEC -> branch_next=1, branch_target=0x20, next pc=0x20. Same with zero=0 -> branch_next=0, next pc=0x14.
3. EXEC with jump=1, jump_target=0x100, branch=1, zero=1 -> next pc=0x100 (jump wins). With halt=1 as well -> pc unchanged, state HALTED, imem_req stays 0.
4. FETCH with imem_ack held 0 for MAX_WAIT=15 cycles -> fetch_error=1, HALTED. Ack arriving on exactly the 15th cycle -> EXEC, no error.
5. pc=0xFFFFFFFC, imm_offset=0xFFFFFFFF, branch taken -> pc_plus4=0x0, branch_target=0xFFFFFFFC. Reset asserted mid-FETCH -> pc=RESET_PC and imem_req=0 immediately.
6. (BRANCH_STATS_EN) three taken branches, one not-taken, one taken-with-jump -> taken_count=3.
